// File: rtl/lda_frame_loader.sv
// lda_frame_loader: framed 16-bit stream receiver that loads LDA weights/thresholds and feature samples.
// Define LDA_FRAME_LOADER_CKSUM_EN to require a trailing wrap-around checksum word on every frame.
module lda_frame_loader #(
  parameter int DIMS    = 6,
  parameter int CLASSES = 3,
  parameter int DW      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic [DW-1:0]                        s_data_i,
  input  logic                                 s_last_i,
  output logic [DIMS-1:0][CLASSES-1:0][DW-1:0] w_o,
  output logic [CLASSES-1:0][DW-1:0]           c_o,
  output logic                                 coef_ok_o,
  output logic [DIMS-1:0][DW-1:0]              din_o,
  output logic                                 din_valid_o,
  input  logic                                 din_ready_i,
  output logic                                 err_o,
  output logic [7:0]                           err_cnt_o
);
  localparam int NW = DIMS * CLASSES;
  localparam int NC = NW + CLASSES;
`ifdef LDA_FRAME_LOADER_CKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int IW = $clog2(NC + EXTRA + 1);
  localparam int CW = $clog2(NC);
  localparam int SW = $clog2(DIMS);
  localparam logic [IW-1:0] NC_I     = IW'(NC);
  localparam logic [IW-1:0] DIMS_I   = IW'(DIMS);
  localparam logic [IW-1:0] COEF_END = IW'(NC + EXTRA - 1);
  localparam logic [IW-1:0] SAMP_END = IW'(DIMS + EXTRA - 1);
  typedef enum logic [1:0] {IDLE, COEF, SAMPLE, DISCARD} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [NC-1:0][DW-1:0] coef_sh, coef_nx;
  logic [DIMS-1:0][DW-1:0] samp_sh, samp_nx;
  logic fire, hdr_bad, at_end, good_end, err;
`ifdef LDA_FRAME_LOADER_CKSUM_EN
  logic [DW-1:0] sum;
  assign good_end = at_end && s_last_i && s_data_i == sum;
`else
  assign good_end = at_end && s_last_i;
`endif
  // the terminating word of a sample frame waits until the output slot is free
  assign s_ready_o = !(state == SAMPLE && idx == SAMP_END && din_valid_o && !din_ready_i);
  assign fire = s_valid_i && s_ready_o;
  assign hdr_bad = s_data_i[DW-1:DW-2] != 2'b01 && s_data_i[DW-1:DW-2] != 2'b10;
  assign at_end = (state == COEF) ? idx == COEF_END : idx == SAMP_END;
  assign err = fire && (state == IDLE ? hdr_bad || s_last_i
                      : (state == COEF || state == SAMPLE) && (s_last_i ? !good_end : at_end));
  // shadow contents including the word being accepted, so a commit sees the final payload word
  always_comb begin
    coef_nx = coef_sh;
    samp_nx = samp_sh;
    if (fire && state == COEF && idx < NC_I) coef_nx[idx[CW-1:0]] = s_data_i;
    if (fire && state == SAMPLE && idx < DIMS_I) samp_nx[idx[SW-1:0]] = s_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      coef_sh     <= '0;
      samp_sh     <= '0;
      w_o         <= '0;
      c_o         <= '0;
      coef_ok_o   <= 1'b0;
      din_o       <= '0;
      din_valid_o <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
`ifdef LDA_FRAME_LOADER_CKSUM_EN
      sum         <= '0;
`endif
    end else begin
      err_o <= err;
      if (err && err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
      if (din_valid_o && din_ready_i) din_valid_o <= 1'b0;
      coef_sh <= coef_nx;
      samp_sh <= samp_nx;
      if (fire) begin
        idx <= idx + IW'(1);
`ifdef LDA_FRAME_LOADER_CKSUM_EN
        sum <= (state == IDLE) ? s_data_i : sum + s_data_i;
`endif
        case (state)
          IDLE: begin
            idx   <= '0;
            state <= s_last_i ? IDLE : hdr_bad ? DISCARD : s_data_i[DW-2] ? COEF : SAMPLE;
          end
          COEF, SAMPLE: begin
            if (s_last_i || at_end) state <= s_last_i ? IDLE : DISCARD;
            if (good_end && state == COEF) begin
              w_o       <= coef_nx[NW-1:0];
              c_o       <= coef_nx[NC-1:NW];
              coef_ok_o <= 1'b1;
            end
            if (good_end && state == SAMPLE) begin
              din_o       <= samp_nx;
              din_valid_o <= 1'b1;
            end
          end
          default: if (s_last_i) state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lda_frame_loader.sv
// tb_lda_frame_loader: directed scenario tests for lda_frame_loader with hand-computed expectations.
module tb_lda_frame_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [15:0] s_data = '0;
  logic s_last = 1'b0;
  logic [5:0][2:0][15:0] w;
  logic [2:0][15:0] c;
  logic coef_ok;
  logic [5:0][15:0] din;
  logic din_valid;
  logic din_ready = 1'b0;
  logic err;
  logic [7:0] err_cnt;
  int checks = 0;
  int errors = 0;

  lda_frame_loader dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .s_last_i(s_last), .w_o(w), .c_o(c), .coef_ok_o(coef_ok),
    .din_o(din), .din_valid_o(din_valid), .din_ready_i(din_ready),
    .err_o(err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // starts and ends on a falling edge; the word is accepted on the rising edge in between
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      errors++;
      $display("FAIL send_timeout word %h never accepted", d);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (w !== '0) begin errors++; $display("FAIL reset_w got %h exp 0", w); end
    checks++; if (c !== '0) begin errors++; $display("FAIL reset_c got %h exp 0", c); end
    checks++; if ({coef_ok, din_valid, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {coef_ok, din_valid, err}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s_ready); end
  endtask

  task automatic test_coef();
    send(16'h4000, 1'b0);
    for (int k = 1; k <= 20; k++) send(16'(k), 1'b0);
    checks++; if (coef_ok !== 1'b0 || w !== '0) begin errors++; $display("FAIL coef_partial got ok=%b w00=%h exp ok=0 w00=0", coef_ok, w[0][0]); end
    send(16'd21, 1'b1);
    checks++; if (w[0][0] !== 16'd1) begin errors++; $display("FAIL coef_w00 got %0d exp 1", w[0][0]); end
    checks++; if (w[1][0] !== 16'd4) begin errors++; $display("FAIL coef_w10 got %0d exp 4", w[1][0]); end
    checks++; if (w[5][2] !== 16'd18) begin errors++; $display("FAIL coef_w52 got %0d exp 18", w[5][2]); end
    checks++; if (c[0] !== 16'd19 || c[2] !== 16'd21) begin errors++; $display("FAIL coef_c got c0=%0d c2=%0d exp 19 21", c[0], c[2]); end
    checks++; if (coef_ok !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL coef_ok got ok=%b err=%b exp 1 0", coef_ok, err); end
    checks++; if (din_valid !== 1'b0) begin errors++; $display("FAIL coef_din_valid got %b exp 0", din_valid); end
  endtask

  task automatic test_sample_stall();
    din_ready = 1'b0;
    send(16'h8000, 1'b0);
    for (int k = 0; k < 6; k++) send(16'h0010 + 16'(k), k == 5);
    checks++; if (din_valid !== 1'b1) begin errors++; $display("FAIL samp_valid got %b exp 1", din_valid); end
    checks++; if (din[5] !== 16'h0015 || din[0] !== 16'h0010) begin errors++; $display("FAIL samp_data got d5=%h d0=%h exp 0015 0010", din[5], din[0]); end
    checks++; if (w[5][2] !== 16'd18) begin errors++; $display("FAIL samp_w_kept got %0d exp 18", w[5][2]); end
    send(16'h8000, 1'b0);
    for (int k = 0; k < 5; k++) send(16'h0020 + 16'(k), 1'b0);
    s_valid = 1'b1; s_data = 16'h0025; s_last = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", s_ready); end
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b0 || din[5] !== 16'h0015) begin errors++; $display("FAIL stall_hold got rdy=%b d5=%h exp 0 0015", s_ready, din[5]); end
    din_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (din_valid !== 1'b1 || din[5] !== 16'h0025 || din[0] !== 16'h0020) begin errors++; $display("FAIL stall_release got v=%b d5=%h d0=%h exp 1 0025 0020", din_valid, din[5], din[0]); end
    @(negedge clk);
    checks++; if (din_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", din_valid); end
    din_ready = 1'b0;
  endtask

  task automatic test_truncated();
    send(16'h4000, 1'b0);
    for (int k = 1; k <= 10; k++) send(16'd100 + 16'(k), k == 10);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL trunc_err got err=%b cnt=%0d exp 1 1", err, err_cnt); end
    checks++; if (w[0][0] !== 16'd1 || c[2] !== 16'd21 || coef_ok !== 1'b1) begin errors++; $display("FAIL trunc_kept got w00=%0d c2=%0d ok=%b exp 1 21 1", w[0][0], c[2], coef_ok); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL trunc_pulse got %b exp 0", err); end
  endtask

  task automatic test_bad_header();
    send(16'hC000, 1'b0);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd2) begin errors++; $display("FAIL badhdr_err got err=%b cnt=%0d exp 1 2", err, err_cnt); end
    send(16'h4000, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    checks++; if (err !== 1'b0 || err_cnt !== 8'd2) begin errors++; $display("FAIL discard_quiet got err=%b cnt=%0d exp 0 2", err, err_cnt); end
    send(16'h8000, 1'b0);
    for (int k = 0; k < 6; k++) send(16'h0030 + 16'(k), k == 5);
    checks++; if (din_valid !== 1'b1 || din[3] !== 16'h0033 || err_cnt !== 8'd2) begin errors++; $display("FAIL badhdr_next got v=%b d3=%h cnt=%0d exp 1 0033 2", din_valid, din[3], err_cnt); end
  endtask

  task automatic test_overlong();
    din_ready = 1'b1;
    @(negedge clk);
    din_ready = 1'b0;
    send(16'h8000, 1'b0);
    for (int k = 0; k < 6; k++) send(16'h0040 + 16'(k), 1'b0);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd3 || din_valid !== 1'b0) begin errors++; $display("FAIL overlong_err got err=%b cnt=%0d v=%b exp 1 3 0", err, err_cnt, din_valid); end
    send(16'h0046, 1'b0);
    send(16'h0047, 1'b1);
    checks++; if (err !== 1'b0 || err_cnt !== 8'd3 || din_valid !== 1'b0 || din[0] !== 16'h0030) begin errors++; $display("FAIL overlong_drop got err=%b cnt=%0d v=%b d0=%h exp 0 3 0 0030", err, err_cnt, din_valid, din[0]); end
  endtask

  task automatic test_back_to_back();
    send(16'h4000, 1'b0);
    for (int k = 0; k < 21; k++) send(16'd200 + 16'(k), k == 20);
    checks++; if (w[0][0] !== 16'd200 || c[2] !== 16'd220 || din_valid !== 1'b0) begin errors++; $display("FAIL b2b_coef got w00=%0d c2=%0d v=%b exp 200 220 0", w[0][0], c[2], din_valid); end
    send(16'h8000, 1'b0);
    for (int k = 0; k < 6; k++) send(16'h0060 + 16'(k), k == 5);
    checks++; if (din_valid !== 1'b1 || din[5] !== 16'h0065 || err_cnt !== 8'd3) begin errors++; $display("FAIL b2b_samp got v=%b d5=%h cnt=%0d exp 1 0065 3", din_valid, din[5], err_cnt); end
    send(16'h4000, 1'b1);
    checks++; if (err !== 1'b1 || err_cnt !== 8'd4) begin errors++; $display("FAIL hdr_last got err=%b cnt=%0d exp 1 4", err, err_cnt); end
  endtask

  task automatic test_err_saturate();
    for (int k = 0; k < 260; k++) send(16'h0000, 1'b1);
    checks++; if (err_cnt !== 8'd255 || err !== 1'b1) begin errors++; $display("FAIL err_sat got cnt=%0d err=%b exp 255 1", err_cnt, err); end
  endtask

  task automatic test_mid_reset();
    send(16'h4000, 1'b0);
    for (int k = 1; k <= 5; k++) send(16'(k), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (w !== '0 || c !== '0 || din !== '0) begin errors++; $display("FAIL midrst_data got w00=%h c2=%h d0=%h exp 0", w[0][0], c[2], din[0]); end
    checks++; if ({coef_ok, din_valid, err} !== 3'b000 || err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_flags got %b cnt=%0d exp 000 0", {coef_ok, din_valid, err}, err_cnt); end
    send(16'h8000, 1'b0);
    for (int k = 0; k < 6; k++) send(16'h0070 + 16'(k), k == 5);
    checks++; if (din_valid !== 1'b1 || din[5] !== 16'h0075 || err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_idle got v=%b d5=%h cnt=%0d exp 1 0075 0", din_valid, din[5], err_cnt); end
  endtask

`ifdef LDA_FRAME_LOADER_CKSUM_EN
  task automatic test_cksum();
    send(16'h8000, 1'b0);
    for (int k = 1; k <= 6; k++) send(16'(k), 1'b0);
    send(16'h8015, 1'b1);
    checks++; if (din_valid !== 1'b1 || din[5] !== 16'd6 || err !== 1'b0) begin errors++; $display("FAIL cksum_good got v=%b d5=%0d err=%b exp 1 6 0", din_valid, din[5], err); end
    din_ready = 1'b1;
    @(negedge clk);
    din_ready = 1'b0;
    send(16'h8000, 1'b0);
    for (int k = 1; k <= 6; k++) send(16'(k), 1'b0);
    send(16'h8016, 1'b1);
    checks++; if (din_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL cksum_bad got v=%b err=%b exp 0 1", din_valid, err); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef LDA_FRAME_LOADER_CKSUM_EN
    test_cksum();
`else
    test_coef();
    test_sample_stall();
    test_truncated();
    test_bad_header();
    test_overlong();
    test_back_to_back();
    test_err_saturate();
    test_mid_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lda_frame_loader.md
Name: lda_frame_loader

Overview:
- Framed 16-bit word-stream receiver that builds the operands consumed by the LDA classifier.
- Coefficient frames load a weight/threshold shadow bank; the live bank is updated atomically only when a frame completes cleanly.
- Sample frames assemble one feature vector, presented downstream through a valid/ready handshake.
- Sits between the host/sensor link and the classifier's din/w/c inputs.

Parameters:
- DIMS, 6, feature dimensions per sample.
- CLASSES, 3, number of classes (weight columns and thresholds).
- DW, 16, word width of stream data and of every operand.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- s_valid_i  in  1  stream word valid.
- s_ready_o  out  1  stream word accepted when s_valid_i && s_ready_o.
- s_data_i  in  DW  stream word.
- s_last_i  in  1  marks the final word of a frame.
- w_o  out  DW x DIMS x CLASSES  live weights.
- c_o  out  DW x CLASSES  live thresholds.
- coef_ok_o  out  1  high once at least one coefficient frame has committed.
- din_o  out  DW x DIMS  assembled sample.
- din_valid_o  out  1  sample available.
- din_ready_i  in  1  downstream accepts sample.
- err_o  out  1  one-cycle pulse on a framing error.
- err_cnt_o  out  8  saturating error count.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - w_o, c_o, din_o, shadows, counters = 0.
  - coef_ok_o, din_valid_o, err_o = 0; err_cnt_o = 0.
  - State = IDLE. Any frame in flight is dropped.
- Header word (first word of every frame), bits [15:14]:
  - 2'b01 = COEF frame: N = DIMS*CLASSES + CLASSES payload words.
  - 2'b10 = SAMPLE frame: N = DIMS payload words.
  - Any other value = bad header.
  - Bits [13:0] are ignored.
- States:
  - IDLE: on accepted header go to COEF or SAMPLE with idx = 0.
    - Bad header: err, then DISCARD; if s_last_i is set on that word, stay in IDLE.
    - Header carrying s_last_i: err, stay in IDLE.
  - COEF: payload word k goes to shadow in order w[0][0], w[0][1]..w[0][CLASSES-1], w[1][0]..w[DIMS-1][CLASSES-1], then c[0]..c[CLASSES-1].
  - SAMPLE: payload word k goes to din shadow[k].
  - DISCARD: accept and drop words until s_last_i, then go to IDLE. No error is raised on exit.
- Frame completion:
  - Word N carrying s_last_i: commit (COEF: shadow -> w_o/c_o, set coef_ok_o; SAMPLE: shadow -> din_o, set din_valid_o), effective next cycle. Return to IDLE.
  - s_last_i on word k < N: err, no commit, go to IDLE. Live outputs are unchanged.
  - Word N without s_last_i: err, no commit, go to DISCARD.
- Handshake:
  - s_ready_o = 1 except in SAMPLE on payload word N while din_valid_o && !din_ready_i; stream stalls until the slot frees.
  - Downstream transfer occurs when din_valid_o && din_ready_i. din_valid_o clears the next cycle unless a new commit lands in the same cycle, in which case it stays 1 with new data.
  - din_o is stable while din_valid_o && !din_ready_i.
- Latency: last accepted word to updated outputs = 1 cycle. A header may follow s_last_i on the very next cycle; no bubble.
- Errors: err_o pulses 1 cycle per error; err_cnt_o increments and saturates at 255.
- COEF commit never disturbs din_o or din_valid_o. Partial COEF frames never reach w_o.

Optional Feature:
- Macro: LDA_FRAME_LOADER_CKSUM_EN.
- Defined:
  - Every frame carries one extra word after the payload: the 16-bit wrap-around sum of the header and all payload words.
  - s_last_i is expected on that checksum word.
  - Mismatch: err, no commit, go to IDLE.
- Undefined: no checksum word; behaviour exactly as above.

Test Plan:
- Reset, then COEF frame: header 0x4000, payload 1..21, s_last_i on 21 -> one cycle later w_o[0][0]=1, w_o[5][2]=18, c_o[2]=21, coef_ok_o=1.
- SAMPLE frame: header 0x8000, payload 0x0010..0x0015 with din_ready_i=0 -> din_valid_o=1, din_o[5]=0x0015. Second SAMPLE frame stalls on its 6th payload word (s_ready_o=0) until din_ready_i=1; then new din_o is presented the cycle after.
- COEF frame truncated (s_last_i on payload word 10) -> err_o pulse, err_cnt_o=1, w_o/c_o keep prior values.
- Bad header 0xC000 followed by 3 words, the last with s_last_i -> one err_o pulse; next valid SAMPLE frame commits normally.
- Overlong SAMPLE frame (s_last_i on word 8) -> err at word 6, words 7-8 discarded, no commit. Then assert rst_i mid-COEF frame -> all outputs 0, state IDLE.
- With LDA_FRAME_LOADER_CKSUM_EN: SAMPLE 0x8000,1,2,3,4,5,6, checksum 0x8015 -> commit; checksum 0x8016 -> err, din_valid_o stays 0.
